// File: rtl/uart_echo_buffer.sv
`default_nettype none
// ============================================================================
// uart_echo_buffer : RX transform -> FIFO -> busy-aware TX drain, plus stats
// Revision 1.0
// ============================================================================
module uart_echo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int HOLDOFF    = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rx_data_ready,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic [1:0]              mode,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic [0:DATA_WIDTH-1]   led,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [CNT_WIDTH-1:0]    rx_count,
  output logic [CNT_WIDTH-1:0]    overflow_count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLDOFF - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [1:0] MODE_INVERT = 2'd1;
  localparam logic [1:0] MODE_SWAP   = 2'd2;
  localparam logic [1:0] MODE_SINK   = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [HOLD_W-1:0]     hold_cnt;
  logic                  hold_done;
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] swapped;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  fifo_full;
  logic                  wr_en;
  logic                  rd_en;
  logic                  drop;

  // ASCII case swap only has meaning for byte-wide words
  generate
    if (DATA_WIDTH == 8) begin : g_case_swap
      always_comb begin
        swapped = rx_data;
        if ((rx_data >= DATA_WIDTH'(8'h41) && rx_data <= DATA_WIDTH'(8'h5A)) ||
            (rx_data >= DATA_WIDTH'(8'h61) && rx_data <= DATA_WIDTH'(8'h7A)))
          swapped = rx_data ^ DATA_WIDTH'(8'h20);
      end
    end else begin : g_no_swap
      assign swapped = rx_data;
    end
  endgenerate

  always_comb begin
    wr_word = rx_data;
    case (mode)
      MODE_INVERT: wr_word = ~rx_data;
      MODE_SWAP:   wr_word = swapped;
      default:     wr_word = rx_data;
    endcase
  end

  // Full is judged on the registered count, so a same-cycle pop never frees a slot
  assign fifo_full = (fifo_count == FULL_COUNT);
  assign wr_en     = rx_data_ready && (mode != MODE_SINK) && !fifo_full;
  assign drop      = rx_data_ready && (mode != MODE_SINK) && fifo_full;
  assign hold_done = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_en)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   fifo_count <= fifo_count + (ADDR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (ADDR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led            <= '0;
      rx_count       <= '0;
      overflow_count <= '0;
    end else begin
      if (rx_data_ready) begin
        led <= rx_data;
        if (rx_count != '1)
          rx_count <= rx_count + CNT_WIDTH'(1);
      end
      if (drop && overflow_count != '1)
        overflow_count <= overflow_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data  <= '0;
      hold_cnt <= '0;
    end else begin
      if (rd_en)
        tx_data <= mem[rd_ptr];
      if (state == S_HOLD && !hold_done)
        hold_cnt <= hold_cnt + HOLD_W'(1);
      else
        hold_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (fifo_count != '0 && !tx_busy) state_next = S_HOLD;
      S_HOLD:  if (hold_done)                    state_next = S_DRAIN;
      S_DRAIN: if (!tx_busy)                     state_next = S_IDLE;
      default:                                   state_next = S_IDLE;
    endcase
  end

  // tx_start marks the first HOLD cycle, when tx_data has just been loaded
  always_comb begin
    rd_en    = 1'b0;
    tx_start = 1'b0;
    case (state)
      S_IDLE:  rd_en    = (fifo_count != '0) && !tx_busy;
      S_HOLD:  tx_start = (hold_cnt == '0);
      default: begin
        rd_en    = 1'b0;
        tx_start = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
